// File: rtl/cam_capture_ctrl.sv
// Camera-to-framebuffer write sequencer: synchronizes an 8-bit parallel camera port,
// pairs RGB565 bytes into RGB332 pixels and drives the frame-buffer RAM write port.
module cam_capture_ctrl #(
   parameter int WIDTH  = 176,
   parameter int HEIGHT = 144,
   parameter int ADDR_W = 15
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              CAM_PCLK,
   input  logic              CAM_HREF,
   input  logic              CAM_VSYNC,
   input  logic [7:0]        CAM_DATA,
   input  logic              CAPTURE_EN,
   output logic [ADDR_W-1:0] W_ADDR,
   output logic [7:0]        W_DATA,
   output logic              W_EN,
   output logic              FRAME_DONE,
   output logic              BUSY,
   output logic              OVERFLOW
);

   localparam int XW = $clog2(WIDTH + 1);
   localparam int YW = $clog2(HEIGHT + 1);
   localparam logic [XW-1:0]     X_MAX     = XW'(WIDTH);
   localparam logic [YW-1:0]     Y_MAX     = YW'(HEIGHT);
   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_VS = 2'd1,
      ST_VS_HIGH = 2'd2,
      ST_ACTIVE  = 2'd3
   } state_t;

   function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] byte1, input logic [7:0] byte2);
      return {byte1[7:5], byte1[2:0], byte2[4:3]};
   endfunction

   state_t state_q, state_d;

   logic pclk_m_q, pclk_s_q, pclk_p_q;
   logic href_m_q, href_s_q, href_p_q;
   logic vs_m_q, vs_s_q, vs_p_q;
   logic [7:0] data_m_q, data_s_q;

   logic [XW-1:0]     x_q, x_d;
   logic [YW-1:0]     y_q, y_d;
   logic [ADDR_W-1:0] line_base_q, line_base_d;
   logic              phase_q, phase_d;
   logic [7:0]        hi_q, hi_d;
   logic              pend_q, pend_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic [7:0]        pend_data_q, pend_data_d;

   logic [ADDR_W-1:0] w_addr_q, w_addr_d;
   logic [7:0]        w_data_q, w_data_d;
   logic              w_en_q, w_en_d;
   logic              fdone_q, fdone_d;
   logic              busy_q, busy_d;
   logic              ovf_q, ovf_d;

   logic pclk_evt_s, line_end_s, frame_end_s;

   // Edge events are all taken from the second synchronizer stage so that
   // HREF, VSYNC and DATA line up with the PCLK edge they belong to.
   assign pclk_evt_s  = pclk_s_q & ~pclk_p_q;
   assign line_end_s  = href_p_q & ~href_s_q;
   assign frame_end_s = vs_s_q & ~vs_p_q;

   // Input synchronizers and edge-detect history
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         pclk_m_q <= 1'b0;
         pclk_s_q <= 1'b0;
         pclk_p_q <= 1'b0;
         href_m_q <= 1'b0;
         href_s_q <= 1'b0;
         href_p_q <= 1'b0;
         vs_m_q   <= 1'b0;
         vs_s_q   <= 1'b0;
         vs_p_q   <= 1'b0;
         data_m_q <= 8'h00;
         data_s_q <= 8'h00;
      end else begin
         pclk_m_q <= CAM_PCLK;
         pclk_s_q <= pclk_m_q;
         pclk_p_q <= pclk_s_q;
         href_m_q <= CAM_HREF;
         href_s_q <= href_m_q;
         href_p_q <= href_s_q;
         vs_m_q   <= CAM_VSYNC;
         vs_s_q   <= vs_m_q;
         vs_p_q   <= vs_s_q;
         data_m_q <= CAM_DATA;
         data_s_q <= data_m_q;
      end
   end

   // Next-state, capture counters and pending-write computation
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      line_base_d = line_base_q;
      phase_d     = phase_q;
      hi_d        = hi_q;
      pend_d      = 1'b0;
      pend_addr_d = pend_addr_q;
      pend_data_d = pend_data_q;
      ovf_d       = ovf_q;
      fdone_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (CAPTURE_EN) state_d = ST_WAIT_VS;
            else            state_d = ST_IDLE;
         end
         ST_WAIT_VS: begin
            if (vs_s_q) state_d = ST_VS_HIGH;
            else        state_d = ST_WAIT_VS;
         end
         ST_VS_HIGH: begin
            x_d         = {XW{1'b0}};
            y_d         = {YW{1'b0}};
            line_base_d = {ADDR_W{1'b0}};
            phase_d     = 1'b0;
            ovf_d       = 1'b0;
            if (!vs_s_q) state_d = ST_ACTIVE;
            else         state_d = ST_VS_HIGH;
         end
         ST_ACTIVE: begin
            if (pclk_evt_s && href_s_q) begin
               if (!phase_q) begin
                  hi_d    = data_s_q;
                  phase_d = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  if ((x_q < X_MAX) && (y_q < Y_MAX)) begin
                     pend_d      = 1'b1;
                     pend_addr_d = line_base_q + ADDR_W'(x_q);
                     pend_data_d = rgb565_to_rgb332(hi_q, data_s_q);
                  end else begin
                     ovf_d = 1'b1;
                  end
                  if (x_q != X_MAX) x_d = x_q + XW'(1);
                  else              x_d = x_q;
               end
            end else if (line_end_s) begin
               // Empty lines do not advance y; an odd trailing byte is dropped.
               x_d     = {XW{1'b0}};
               phase_d = 1'b0;
               if ((x_q != {XW{1'b0}}) && (y_q < Y_MAX)) begin
                  y_d         = y_q + YW'(1);
                  line_base_d = line_base_q + LINE_STEP;
               end else begin
                  y_d = y_q;
               end
            end else begin
               x_d = x_q;
            end
            if (frame_end_s) begin
               fdone_d = 1'b1;
               if (CAPTURE_EN) state_d = ST_VS_HIGH;
               else            state_d = ST_IDLE;
            end else begin
               state_d = ST_ACTIVE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output stage: one registered write per pending pixel, address/data held otherwise
   always_comb begin
      w_en_d = pend_q;
      busy_d = (state_d != ST_IDLE);
      if (pend_q) begin
         w_addr_d = pend_addr_q;
         w_data_d = pend_data_q;
      end else begin
         w_addr_d = w_addr_q;
         w_data_d = w_data_q;
      end
   end

   // State, capture and output registers
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         x_q         <= {XW{1'b0}};
         y_q         <= {YW{1'b0}};
         line_base_q <= {ADDR_W{1'b0}};
         phase_q     <= 1'b0;
         hi_q        <= 8'h00;
         pend_q      <= 1'b0;
         pend_addr_q <= {ADDR_W{1'b0}};
         pend_data_q <= 8'h00;
         w_addr_q    <= {ADDR_W{1'b0}};
         w_data_q    <= 8'h00;
         w_en_q      <= 1'b0;
         fdone_q     <= 1'b0;
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         line_base_q <= line_base_d;
         phase_q     <= phase_d;
         hi_q        <= hi_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
         w_addr_q    <= w_addr_d;
         w_data_q    <= w_data_d;
         w_en_q      <= w_en_d;
         fdone_q     <= fdone_d;
         busy_q      <= busy_d;
         ovf_q       <= ovf_d;
      end
   end

   assign W_ADDR     = w_addr_q;
   assign W_DATA     = w_data_q;
   assign W_EN       = w_en_q;
   assign FRAME_DONE = fdone_q;
   assign BUSY       = busy_q;
   assign OVERFLOW   = ovf_q;

endmodule
